register_bank: RTL and testbench



---
 rtl/register_bank.sv | 69 ++++++
 tb/tb_register_bank.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/register_bank.sv
// Eight-entry register storage with one-hot write select, two registered read ports with
// write-to-read bypass, and a sticky error flag for malformed load vectors.
module register_bank #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [7:0]       load,
  input  logic [WIDTH-1:0] wdata,
  input  logic [2:0]       ra,
  input  logic [2:0]       rb,
  input  logic             clr_err,
  output logic [WIDTH-1:0] qa,
  output logic [WIDTH-1:0] qb,
  output logic             err
);

  logic [WIDTH-1:0] regs_q [8];
  logic [WIDTH-1:0] qa_q, qa_d;
  logic [WIDTH-1:0] qb_q, qb_d;
  logic             err_q, err_d;
  logic [7:0]       load_m1;
  logic             load_onehot;
  logic             wr_valid;
  logic             wr_reject;

  // Clearing the lowest set bit leaves zero only for a single-bit vector.
  assign load_m1     = load - 8'd1;
  assign load_onehot = (load != 8'd0) && ((load & load_m1) == 8'd0);
  assign wr_valid    = we & load_onehot;
  assign wr_reject   = we & ~load_onehot;

  always_comb begin
    qa_d  = (wr_valid && load[ra]) ? wdata : regs_q[ra];
    qb_d  = (wr_valid && load[rb]) ? wdata : regs_q[rb];
    err_d = err_q;
    if (wr_reject) begin
      err_d = 1'b1;
    end else if (clr_err) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= '0;
      end
      qa_q  <= '0;
      qb_q  <= '0;
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (wr_valid && load[i]) begin
          regs_q[i] <= wdata;
        end
      end
      qa_q  <= qa_d;
      qb_q  <= qb_d;
      err_q <= err_d;
    end
  end

  assign qa  = qa_q;
  assign qb  = qb_q;
  assign err = err_q;

endmodule

// File: tb/tb_register_bank.sv
// Directed table-driven bench for register_bank, plus hand sequences for back-to-back
// writes and asynchronous reset during a write.
module tb_register_bank;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       we = 1'b0;
  logic [7:0] load = 8'h00;
  logic [7:0] wdata = 8'h00;
  logic [2:0] ra = 3'd0;
  logic [2:0] rb = 3'd0;
  logic       clr_err = 1'b0;
  logic [7:0] qa;
  logic [7:0] qb;
  logic       err;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic       we;
    logic [7:0] load;
    logic [7:0] wdata;
    logic [2:0] ra;
    logic [2:0] rb;
    logic       clr;
    logic [7:0] eqa;
    logic [7:0] eqb;
    logic       eerr;
  } vec_t;

  vec_t vecs[$];

  register_bank #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .load    (load),
    .wdata   (wdata),
    .ra      (ra),
    .rb      (rb),
    .clr_err (clr_err),
    .qa      (qa),
    .qb      (qb),
    .err     (err)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic w, logic [7:0] l, logic [7:0] d, logic [2:0] a,
                              logic [2:0] b, logic c, logic [7:0] ea, logic [7:0] eb,
                              logic ee);
    vec_t v;
    v.we = w; v.load = l; v.wdata = d; v.ra = a; v.rb = b; v.clr = c;
    v.eqa = ea; v.eqb = eb; v.eerr = ee;
    return v;
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [7:0] l, input logic [7:0] d,
                       input logic [2:0] a, input logic [2:0] b, input logic c);
    we = w; load = l; wdata = d; ra = a; rb = b; clr_err = c;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Table: write sweep with same-cycle bypass, read sweep, bypass, rejects, err clear.
    for (int i = 0; i < 8; i++) begin
      vecs.push_back(mk(1'b1, 8'(1 << i), 8'(8'hA0 + i), 3'(i), 3'(i), 1'b0,
                        8'(8'hA0 + i), 8'(8'hA0 + i), 1'b0));
    end
    for (int i = 0; i < 8; i++) begin
      vecs.push_back(mk(1'b0, 8'h00, 8'h00, 3'(i), 3'(7 - i), 1'b0,
                        8'(8'hA0 + i), 8'(8'hA7 - i), 1'b0));
    end
    vecs.push_back(mk(1'b1, 8'h08, 8'h3C, 3'd0, 3'd0, 1'b0, 8'hA0, 8'hA0, 1'b0));
    vecs.push_back(mk(1'b0, 8'h00, 8'h00, 3'd3, 3'd3, 1'b0, 8'h3C, 8'h3C, 1'b0));
    vecs.push_back(mk(1'b1, 8'h08, 8'h5A, 3'd3, 3'd3, 1'b0, 8'h5A, 8'h5A, 1'b0));
    vecs.push_back(mk(1'b0, 8'h00, 8'h00, 3'd3, 3'd3, 1'b0, 8'h5A, 8'h5A, 1'b0));
    vecs.push_back(mk(1'b1, 8'h00, 8'hFF, 3'd3, 3'd0, 1'b0, 8'h5A, 8'hA0, 1'b1));
    vecs.push_back(mk(1'b1, 8'h0C, 8'hEE, 3'd2, 3'd3, 1'b0, 8'hA2, 8'h5A, 1'b1));
    vecs.push_back(mk(1'b0, 8'h00, 8'h00, 3'd2, 3'd0, 1'b0, 8'hA2, 8'hA0, 1'b1));
    vecs.push_back(mk(1'b0, 8'h00, 8'h00, 3'd0, 3'd7, 1'b1, 8'hA0, 8'hA7, 1'b0));
    vecs.push_back(mk(1'b1, 8'h81, 8'h77, 3'd0, 3'd7, 1'b1, 8'hA0, 8'hA7, 1'b1));
    vecs.push_back(mk(1'b0, 8'hFF, 8'h66, 3'd0, 3'd7, 1'b0, 8'hA0, 8'hA7, 1'b1));
    vecs.push_back(mk(1'b0, 8'h00, 8'h00, 3'd1, 3'd6, 1'b1, 8'hA1, 8'hA6, 1'b0));
    vecs.push_back(mk(1'b0, 8'hFF, 8'h55, 3'd1, 3'd6, 1'b0, 8'hA1, 8'hA6, 1'b0));

    // Outputs are zero while held in reset, before any clock edge.
    #3;
    check("rst_qa", qa, 8'h00);
    check("rst_qb", qb, 8'h00);
    check("rst_err", {7'd0, err}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    foreach (vecs[k]) begin
      drive(vecs[k].we, vecs[k].load, vecs[k].wdata, vecs[k].ra, vecs[k].rb, vecs[k].clr);
      step();
      check($sformatf("vec%0d_qa", k), qa, vecs[k].eqa);
      check($sformatf("vec%0d_qb", k), qb, vecs[k].eqb);
      check($sformatf("vec%0d_err", k), {7'd0, err}, {7'd0, vecs[k].eerr});
    end

    // Back-to-back: port A reads the register written one cycle earlier, port B bypasses.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'(1 << i), 8'(8'hC0 + i), 3'((i + 7) % 8), 3'(i), 1'b0);
      step();
      if (i > 0) check($sformatf("b2b%0d_qa", i), qa, 8'(8'hC0 + i - 1));
      check($sformatf("b2b%0d_qb", i), qb, 8'(8'hC0 + i));
      check($sformatf("b2b%0d_err", i), {7'd0, err}, 8'h00);
    end
    drive(1'b0, 8'h00, 8'h00, 3'd7, 3'd0, 1'b0);
    step();
    check("b2b_last_qa", qa, 8'hC7);
    check("b2b_last_qb", qb, 8'hC0);

    // Reset values: fill 0x11..0x88, set err, then reset mid-cycle during a write.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'(1 << i), 8'(8'h11 * (i + 1)), 3'(i), 3'(i), 1'b0);
      step();
    end
    check("fill_qa", qa, 8'h88);
    drive(1'b1, 8'h00, 8'h00, 3'd7, 3'd6, 1'b0);
    step();
    check("fill_err", {7'd0, err}, 8'h01);
    check("fill_qb", qb, 8'h77);
    drive(1'b1, 8'h01, 8'hFF, 3'd0, 3'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_qa", qa, 8'h00);
    check("async_rst_qb", qb, 8'h00);
    check("async_rst_err", {7'd0, err}, 8'h00);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00, 3'd0, 3'd0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 8'h00, 8'h00, 3'(i), 3'(7 - i), 1'b0);
      step();
      check($sformatf("post_rst%0d_qa", i), qa, 8'h00);
      check($sformatf("post_rst%0d_qb", i), qb, 8'h00);
    end
    check("post_rst_err", {7'd0, err}, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
